// File: rtl/decoder_stream.sv
// ---------------------------------------------------------------------------
// decoder_stream
//
// Registered binary-to-vector decoder with a valid/ready front end and a
// 2-entry result buffer. The buffer decouples the select-producing control
// FSM from backpressure in the downstream enable/strobe fabric. A request
// is decoded when it is accepted, and the result is stored together with an
// error flag. A saturating counter tracks how many error-free results have
// been delivered.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      upstream request valid
//   in_ready   out  1      block can accept a request (0 during reset)
//   in_sel     in   SEL_W  index to decode
//   in_mode    in   2      00 one-hot, 01 thermometer, 10 inverted one-hot,
//                          11 reserved (error)
//   out_valid  out  1      buffered result available
//   out_ready  in   1      downstream accepts the head result
//   out_y      out  OUT_W  decoded vector of the head entry (0 when empty)
//   out_err    out  1      head entry is an error result (0 when empty)
//   dec_count  out  CNT_W  error-free deliveries, saturating
// ---------------------------------------------------------------------------
module decoder_stream #(
    parameter int SEL_W     = 3,
    parameter int MAX_IDX   = 2**SEL_W - 1,
    parameter bit ZERO_IDX0 = 1'b1,
    parameter int CNT_W     = 16,
    localparam int OUT_W    = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_err,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_INV    = 2'b10;

    // One extra bit so the range check stays meaningful when MAX_IDX is
    // the largest value representable in SEL_W bits.
    localparam logic [SEL_W:0] MAX_SEL_EXT = (SEL_W+1)'(MAX_IDX);

    // Returns {err, y} for one request.
    function automatic logic [OUT_W:0] decode_f(
        input logic [SEL_W-1:0] sel,
        input logic [1:0]       mode
    );
        logic [OUT_W-1:0] onehot;
        logic [OUT_W-1:0] y;
        logic             err;
        onehot = OUT_W'(1'b1) << sel;
        // Legacy behaviour: index 0 means "nothing selected".
        if (ZERO_IDX0 && (sel == '0)) begin
            onehot = '0;
        end else begin
            onehot = onehot;
        end
        err = ({1'b0, sel} > MAX_SEL_EXT) || (mode == 2'b11);
        case (mode)
            MODE_ONEHOT: y = onehot;
            MODE_THERM:  y = (OUT_W'(1'b1) << sel) - OUT_W'(1'b1);
            MODE_INV:    y = ~onehot;
            default:     y = '0;
        endcase
        if (err) begin
            y = '0;
        end else begin
            y = y;
        end
        return {err, y};
    endfunction

    // Buffer storage and bookkeeping
    logic [OUT_W-1:0] y_mem_q [2];
    logic [1:0]       err_mem_q;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic             deliver_s;
    logic [OUT_W:0]   dec_s;
    logic             head_err_s;

    // Handshake qualifiers and decode of the current request
    always_comb begin
        in_ready   = (occ_q != 2'd2) && !rst;
        out_valid  = (occ_q != 2'd0);
        accept_s   = in_valid && in_ready;
        deliver_s  = out_valid && out_ready;
        dec_s      = decode_f(in_sel, in_mode);
        head_err_s = err_mem_q[rd_ptr_q];
    end

    // Next-state for pointers, occupancy and the delivery counter
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (accept_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deliver_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Simultaneous accept and deliver leaves occupancy unchanged.
        case ({accept_s, deliver_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (deliver_s && !head_err_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards buffered entries
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            cnt_q      <= '0;
            y_mem_q[0] <= '0;
            y_mem_q[1] <= '0;
            err_mem_q  <= 2'b00;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            // Only an accepted request touches storage, so select/mode
            // values present while in_valid=0 never reach the buffer.
            if (accept_s) begin
                y_mem_q[wr_ptr_q]   <= dec_s[OUT_W-1:0];
                err_mem_q[wr_ptr_q] <= dec_s[OUT_W];
            end else begin
                y_mem_q[wr_ptr_q]   <= y_mem_q[wr_ptr_q];
                err_mem_q[wr_ptr_q] <= err_mem_q[wr_ptr_q];
            end
        end
    end

    // Head-entry presentation, forced to zero while the buffer is empty
    always_comb begin
        if (out_valid) begin
            out_y   = y_mem_q[rd_ptr_q];
            out_err = head_err_s;
        end else begin
            out_y   = '0;
            out_err = 1'b0;
        end
        dec_count = cnt_q;
    end

endmodule
